// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//
// Ports:
//   clk        sole clock, rising edge
//   resetn     asynchronous active-low reset
//   req_valid  request present; req_ready high when idle and able to accept
//   req_op     0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (no write)
//   op_a       rs operand / dividend / MTHI-MTLO source
//   op_b       rt operand / divisor
//   flush      cancels any operation, suppresses strobes, blocks acceptance
//   busy       high whenever not idle
//   hi_we/hi_o HI write strobe and data (one cycle, in DONE only)
//   lo_we/lo_o LO write strobe and data (one cycle, in DONE only)
//
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle 64-bit multiply
// (MULT/MULTU go straight from IDLE to DONE). Division is always iterative.
module muldiv_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic        hi_we,
  output logic [31:0] hi_o,
  output logic        lo_we,
  output logic [31:0] lo_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
`ifdef MULDIV_FAST_MUL_EN
  localparam logic [1:0] MUL_ST = DONE;
`else
  localparam logic [1:0] MUL_ST = MUL;
`endif
  logic [1:0]  state, state_nx;
  logic [4:0]  cnt;
  logic [2:0]  op;
  logic [31:0] a_q, ma, mb, a_mag, b_mag, dsub, quo, rem;
  logic        neg_p, neg_r, dz, accept, sgn, dge;
  logic [32:0] sum;
  logic [63:0] acc, prod, mul_init;
  assign req_ready = state == IDLE;
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready & ~flush;
  // even op codes (MULT, DIV) are the signed forms
  assign sgn   = ~req_op[0];
  assign a_mag = sgn & op_a[31] ? -op_a : op_a;
  assign b_mag = sgn & op_b[31] ? -op_b : op_b;
`ifdef MULDIV_FAST_MUL_EN
  assign mul_init = {32'd0, a_mag} * {32'd0, b_mag};
`else
  assign mul_init = {32'd0, b_mag};
`endif
  // shift-add step: acc = {partial product high, remaining multiplier bits}
  assign sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, ma} : 33'd0);
  // restoring step: shifted remainder is {acc[63], acc[62:31]}; the true
  // difference always fits in 32 bits when it is non-negative
  assign dge  = acc[63] | (acc[62:31] >= mb);
  assign dsub = acc[62:31] - mb;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = flush ? IDLE
             : state == IDLE ? (accept ? (req_op[2] ? DONE : req_op[1] ? DIV : MUL_ST) : IDLE)
             : state == DONE ? IDLE
             : &cnt ? DONE : state;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt   <= '0;
      op    <= '0;
      a_q   <= '0;
      ma    <= '0;
      mb    <= '0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      acc   <= '0;
    end else if (accept) begin
      cnt   <= '0;
      op    <= req_op;
      a_q   <= op_a;
      ma    <= a_mag;
      mb    <= b_mag;
      neg_p <= sgn & (op_a[31] ^ op_b[31]);
      neg_r <= sgn & op_a[31];
      dz    <= op_b == 32'd0;
      acc   <= req_op[1] ? {32'd0, a_mag} : mul_init;
    end else if (state == MUL) begin
      acc <= {sum, acc[31:1]};
      cnt <= cnt + 5'd1;
    end else if (state == DIV) begin
      acc <= dge ? {dsub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
      cnt <= cnt + 5'd1;
    end
  // sign fix-up; divide-by-zero returns all-ones quotient and the raw dividend
  assign prod = neg_p ? -acc : acc;
  assign quo  = dz ? '1 : neg_p ? -acc[31:0] : acc[31:0];
  assign rem  = dz ? a_q : neg_r ? -acc[63:32] : acc[63:32];
  always_comb begin
    hi_we = state == DONE && !flush && (!op[2] || op == 3'd4);
    lo_we = state == DONE && !flush && (!op[2] || op == 3'd5);
    hi_o  = !hi_we ? '0 : op[2] ? a_q : op[1] ? rem : prod[63:32];
    lo_o  = !lo_we ? '0 : op[2] ? a_q : op[1] ? quo : prod[31:0];
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
  localparam int mul_lat = 1;
`else
  localparam int mul_lat = 33;
`endif
  localparam int div_lat = 33;
  logic        clk = 1'b0, resetn = 1'b0, req_valid = 1'b0, flush = 1'b0;
  logic        req_ready, busy, hi_we, lo_we;
  logic [2:0]  req_op = '0;
  logic [31:0] op_a = '0, op_b = '0, hi_o, lo_o;
  int checks = 0, failures = 0;
  logic seen;
  muldiv_unit dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy),
    .hi_we(hi_we), .hi_o(hi_o), .lo_we(lo_we), .lo_o(lo_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_hi_we"}, 32'(hi_we),     32'd0);
    check({tag, "_lo_we"}, 32'(lo_we),     32'd0);
    check({tag, "_hi_o"},  hi_o,           32'd0);
    check({tag, "_lo_o"},  lo_o,           32'd0);
  endtask
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic ehw, input logic elw,
                        input logic [31:0] eh, input logic [31:0] el);
    logic early;
    early = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; op_a = a; op_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n < lat; n++) begin
      @(negedge clk);
      early |= hi_we | lo_we;
    end
    @(negedge clk);
    check({tag, "_early"}, 32'(early), 32'd0);
    check({tag, "_hi_we"}, 32'(hi_we), 32'(ehw));
    check({tag, "_lo_we"}, 32'(lo_we), 32'(elw));
    if (ehw) check({tag, "_hi"}, hi_o, eh);
    if (elw) check({tag, "_lo"}, lo_o, el);
    @(negedge clk);
    check({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask
  initial begin
    #1 check_reset_outputs("in_reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");
    run_op("mult_m3x7",   3'd0, -32'sd3, 32'd7, mul_lat, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_m5xm6",  3'd0, -32'sd5, -32'sd6, mul_lat, 1, 1, 32'd0, 32'd30);
    run_op("mult_maxmin", 3'd0, 32'h7FFF_FFFF, 32'h8000_0000, mul_lat, 1, 1, 32'hC000_0000, 32'h8000_0000);
    run_op("multu_ones",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mul_lat, 1, 1, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("multu_2p32",  3'd1, 32'h0001_0000, 32'h0001_0000, mul_lat, 1, 1, 32'd1, 32'd0);
    run_op("divu_100_7",  3'd3, 32'd100, 32'd7, div_lat, 1, 1, 32'd2, 32'd14);
    run_op("div_m7_2",    3'd2, -32'sd7, 32'd2, div_lat, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2",    3'd2, 32'd7, -32'sd2, div_lat, 1, 1, 32'd1, 32'hFFFF_FFFD);
    run_op("divu_max_2",  3'd3, 32'hFFFF_FFFF, 32'd2, div_lat, 1, 1, 32'd1, 32'h7FFF_FFFF);
    run_op("divu_big",    3'd3, 32'h8000_0000, 32'hFFFF_FFFF, div_lat, 1, 1, 32'h8000_0000, 32'd0);
    run_op("div_5_0",     3'd2, 32'd5, 32'd0, div_lat, 1, 1, 32'd5, 32'hFFFF_FFFF);
    run_op("div_m9_0",    3'd2, -32'sd9, 32'd0, div_lat, 1, 1, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
    run_op("divu_x_0",    3'd3, 32'h8000_0000, 32'd0, div_lat, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_ovf",     3'd2, 32'h8000_0000, 32'hFFFF_FFFF, div_lat, 1, 1, 32'd0, 32'h8000_0000);
    run_op("mthi",        3'd4, 32'hDEAD_BEEF, 32'd9, 1, 1, 0, 32'hDEAD_BEEF, 32'd0);
    run_op("mtlo",        3'd5, 32'hCAFE_0001, 32'd9, 1, 0, 1, 32'd0, 32'hCAFE_0001);
    run_op("rsv6",        3'd6, 32'h1111_1111, 32'd1, 1, 0, 0, 32'd0, 32'd0);
    run_op("rsv7",        3'd7, 32'h2222_2222, 32'd1, 1, 0, 0, 32'd0, 32'd0);
    // request held while a divide is in flight
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd3; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk);
    #1 req_op = 3'd5; op_a = 32'h0000_1234;
    seen = 1'b0;
    @(negedge clk);
    check("hold_busy",  32'(busy),      32'd1);
    check("hold_ready", 32'(req_ready), 32'd0);
    for (int n = 2; n < 33; n++) begin
      @(negedge clk);
      seen |= hi_we | lo_we;
    end
    @(negedge clk);
    check("hold_early", 32'(seen), 32'd0);
    check("hold_lo_we", 32'(lo_we), 32'd1);
    check("hold_lo",    lo_o, 32'd14);
    check("hold_hi",    hi_o, 32'd2);
    @(negedge clk);
    check("hold_ready_again", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("hold_mtlo_lo_we", 32'(lo_we), 32'd1);
    check("hold_mtlo_hi_we", 32'(hi_we), 32'd0);
    check("hold_mtlo_lo",    lo_o, 32'h0000_1234);
    // flush mid-divide at T+10
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd3; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_idle", 32'(req_ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      seen |= hi_we | lo_we;
    end
    check("flush_no_strobe", 32'(seen), 32'd0);
    // flush in DONE suppresses the MTHI strobe
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; op_a = 32'h5555_AAAA;
    @(posedge clk);
    #1 req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flush_done_hi_we", 32'(hi_we), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_done_idle", 32'(req_ready), 32'd1);
    check("flush_done_after", 32'(hi_we), 32'd0);
    // flush blocks acceptance in its own cycle
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; op_a = 32'h7777_0000; flush = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_block_ready", 32'(req_ready), 32'd1);
    check("flush_block_hi_we", 32'(hi_we), 32'd0);
    // asynchronous reset at T+20 of a MULTU
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd1; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      seen |= hi_we | lo_we;
    end
    check("reset_no_strobe", 32'(seen), 32'd0);
    run_op("mult_after_rst", 3'd0, -32'sd3, 32'd7, mul_lat, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
